bp_gshare: RTL and testbench

- Gshare conditional-branch direction predictor for the RV32I pipeline.
- Fetch queries it with the branch PC and gets a taken/not-taken guess one cycle later.
- Execute trains it with the resolved comparator outcome (br_en) and, on mispredict, repairs the global history register.
- Complements the execute-stage comparator: the comparator resolves branches, this block predicts them and consumes the resolutions.

---
 rtl/rv32i_types.sv | 18 +
 rtl/bp_sat_ctr.sv | 21 ++
 rtl/bp_gshare.sv | 125 ++++++++++++
 tb/tb_bp_gshare.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch-predictor counter and FSM encodings.
package rv32i_types;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    typedef enum logic {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_t;

    localparam bp_ctr_t BP_CTR_RESET = WNT;

endpackage

// File: rtl/bp_sat_ctr.sv
// Two-bit saturating counter next-state: taken counts up, not-taken counts down.
module bp_sat_ctr
    import rv32i_types::*;
(
    input  bp_ctr_t ctr_i,
    input  logic    taken_i,
    output bp_ctr_t ctr_c_o
);

    always_comb begin
        ctr_c_o = ctr_i;
        case (ctr_i)
            SNT:     ctr_c_o = taken_i ? WNT : SNT;
            WNT:     ctr_c_o = taken_i ? WT  : SNT;
            WT:      ctr_c_o = taken_i ? ST  : WNT;
            ST:      ctr_c_o = taken_i ? ST  : WT;
            default: ctr_c_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/bp_gshare.sv
// Gshare direction predictor: PC xor global history indexes a table of 2-bit counters;
// the table is swept to WNT after reset before requests are accepted.
module bp_gshare
    import rv32i_types::*;
#(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_ready,
    output logic                pred_resp_valid,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_taken,
    input  logic                upd_mispredict
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    bp_state_t             state_q, state_d;
    logic [IDX_BITS-1:0]   ptr_q, ptr_d;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic                  ready_q;
    logic                  resp_valid_q;
    logic                  taken_q;
    logic [GHR_BITS-1:0]   pghr_q;
    bp_ctr_t               table_q [ENTRIES];

    logic                  init_we_c;
    logic                  pred_acc_c;
    logic                  upd_en_c;
    logic [IDX_BITS-1:0]   pred_idx_c;
    logic [IDX_BITS-1:0]   upd_idx_c;
    bp_ctr_t               pred_ctr_c;
    bp_ctr_t               upd_ctr_c;
    logic                  unused_pc_bits_c;

    assign pred_idx_c = pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign upd_idx_c  = upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(upd_ghr);
    assign pred_ctr_c = table_q[pred_idx_c];
    assign pred_acc_c = pred_valid & (state_q == BP_READY);
    assign upd_en_c   = upd_valid & (state_q == BP_READY);

    assign unused_pc_bits_c = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                                upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

    bp_sat_ctr u_sat_ctr (
        .ctr_i   (table_q[upd_idx_c]),
        .taken_i (upd_taken),
        .ctr_c_o (upd_ctr_c)
    );

    // Init sweep: one table entry per cycle, then park in READY until reset.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        init_we_c = 1'b0;
        case (state_q)
            BP_INIT: begin
                init_we_c = 1'b1;
                ptr_d     = ptr_q + IDX_BITS'(1);
                if (ptr_q == IDX_BITS'(ENTRIES - 1)) begin
                    state_d = BP_READY;
                end
            end
            BP_READY: begin
                state_d = BP_READY;
            end
            default: state_d = BP_INIT;
        endcase
    end

    // Mispredict repair overrides the speculative shift of the current prediction.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_en_c && upd_mispredict) begin
            ghr_d = GHR_BITS'({upd_ghr, upd_taken});
        end else if (pred_acc_c) begin
            ghr_d = GHR_BITS'({ghr_q, pred_ctr_c[1]});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BP_INIT;
            ptr_q        <= '0;
            ghr_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            taken_q      <= 1'b0;
            pghr_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ghr_q        <= ghr_d;
            ready_q      <= (state_d == BP_READY);
            resp_valid_q <= pred_acc_c;
            if (pred_acc_c) begin
                taken_q <= pred_ctr_c[1];
                pghr_q  <= ghr_q;
            end
        end
    end

    // Table is fully rewritten by the init sweep, so it carries no reset.
    always_ff @(posedge clk) begin
        if (init_we_c) begin
            table_q[ptr_q] <= BP_CTR_RESET;
        end else if (upd_en_c) begin
            table_q[upd_idx_c] <= upd_ctr_c;
        end
    end

    assign pred_ready      = ready_q;
    assign pred_resp_valid = resp_valid_q;
    assign pred_taken      = taken_q;
    assign pred_ghr        = pghr_q;

endmodule

// File: tb/tb_bp_gshare.sv
// Randomised scoreboard bench for bp_gshare against an array-based gshare reference model.
module tb_bp_gshare;

    localparam int NENT = 64;
    localparam int GMOD = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_ready;
    logic        pred_resp_valid;
    logic        pred_taken;
    logic [5:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    bp_gshare #(.IDX_BITS(6), .GHR_BITS(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .pred_valid      (pred_valid),
        .pred_pc         (pred_pc),
        .pred_ready      (pred_ready),
        .pred_resp_valid (pred_resp_valid),
        .pred_taken      (pred_taken),
        .pred_ghr        (pred_ghr),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_ghr         (upd_ghr),
        .upd_taken       (upd_taken),
        .upd_mispredict  (upd_mispredict)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [6:0] exp_q [$];
    int ent [NENT];
    int m_ghr;
    int edges;

    // Monitor: every presented response must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [6:0] e;
        if (pred_resp_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected: got taken=%b ghr=%b, required no response", pred_taken, pred_ghr);
            end else begin
                e = exp_q.pop_front();
                if ({pred_taken, pred_ghr} !== e) begin
                    n_bad++;
                    $display("FAIL resp: got taken=%b ghr=%b, required taken=%b ghr=%b",
                             pred_taken, pred_ghr, e[6], e[5:0]);
                end
            end
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < NENT; i++) ent[i] = 1;
        m_ghr = 0;
        edges = 0;
    endfunction

    // Called at a negedge; applies one cycle of stimulus and leaves at the next negedge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic uv,
                        input logic [31:0] upc, input logic [5:0] ughr,
                        input logic ut, input logic um);
        int  idx, ui;
        bit  rdy, ptk;
        rdy = (edges >= NENT);
        n_vec++;
        if (pred_ready !== rdy) begin
            n_bad++;
            $display("FAIL pred_ready: got %b, required %b after %0d init edges", pred_ready, rdy, edges);
        end
        pred_valid     = pv;
        pred_pc        = ppc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_ghr        = ughr;
        upd_taken      = ut;
        upd_mispredict = um;
        ptk = 1'b0;
        if (rdy) begin
            if (pv) begin
                idx = int'((ppc >> 2) & 32'h3F) ^ m_ghr;
                ptk = (ent[idx] >= 2);
                exp_q.push_back({ptk, 6'(m_ghr)});
            end
            if (uv) begin
                ui = int'((upc >> 2) & 32'h3F) ^ int'(ughr);
                if (ut) ent[ui] = (ent[ui] == 3) ? 3 : ent[ui] + 1;
                else    ent[ui] = (ent[ui] == 0) ? 0 : ent[ui] - 1;
            end
            if (uv && um)  m_ghr = (int'(ughr) * 2 + int'(ut)) % GMOD;
            else if (pv)   m_ghr = (m_ghr * 2 + int'(ptk)) % GMOD;
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
    endtask

    task automatic rand_step(input int pv_pct);
        step(($urandom_range(0, 99) < pv_pct), $urandom & 32'h0000_03FC,
             $urandom_range(0, 1) == 1, $urandom & 32'h0000_03FC,
             6'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Reset spanning one posedge; checks the reset values of every output.
    task automatic do_reset();
        rst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        #1;
        n_vec++;
        if ({pred_ready, pred_resp_valid, pred_taken, pred_ghr} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ready=%b resp=%b taken=%b ghr=%b, required all 0",
                     pred_ready, pred_resp_valid, pred_taken, pred_ghr);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        do_reset();

        // Init with traffic that must be ignored, then a first prediction.
        for (int i = 0; i < NENT; i++) rand_step(50);
        step(1'b1, 32'h100, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);

        // Train index 0 taken, then saturate and walk back down.
        repeat (2) step(1'b0, 32'h0, 1'b1, 32'h100, 6'h0, 1'b1, 1'b0);
        step(1'b1, 32'h100, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b1, 32'h100, 6'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h100, 6'h0, 1'b0, 1'b0);
        step(1'b1, 32'(((0 ^ m_ghr) | 64) << 2), 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b1, 32'h100, 6'h0, 1'b0, 1'b0);
        step(1'b1, 32'(((0 ^ m_ghr) | 64) << 2), 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);

        // Mispredict repair racing a taken prediction on index 5.
        repeat (2) step(1'b0, 32'h0, 1'b1, 32'h14, 6'h0, 1'b1, 1'b0);
        step(1'b1, 32'((5 ^ m_ghr) << 2), 1'b1, 32'h300, 6'b000101, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);

        // Read/write collision on a fresh WNT entry.
        step(1'b1, 32'((22 ^ m_ghr) << 2), 1'b1, 32'((22 ^ m_ghr) << 2), 6'(m_ghr), 1'b1, 1'b0);
        step(1'b1, 32'((22 ^ m_ghr) << 2), 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);

        for (int i = 0; i < 500; i++) rand_step(60);
        idle();

        // Reset mid-init with updates during the sweep.
        do_reset();
        for (int i = 0; i < 30; i++) rand_step(50);
        do_reset();
        for (int i = 0; i < NENT; i++) rand_step(50);
        for (int i = 0; i < 16; i++) step(1'b1, $urandom & 32'h0000_03FC, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) rand_step(70);
        repeat (3) idle();

        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL resp_missing: %0d responses outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
